// File: rtl/tx_ltssm.sv
// Transmit half of the LTSSM training datapath: per-lane TS1/TS2/Idle ordered-set generator with quota tracking.
// Optional macro TX_LTSSM_FAST_SIM_EN shortens the Polling.Active transmit quota for simulation.

module tx_ltssm_lane #(
  parameter int          LANE       = 0,
  parameter int          DEVICETYPE = 0,
  parameter logic [7:0]  NFTS       = 8'd255
) (
  input  logic [3:0]   ls_i,
  input  logic [7:0]   link_i,
  input  logic [6:0]   rate_i,
  input  logic         upcfg_i,
  input  logic [4:0]   nlanes_i,
  output logic [127:0] os_o
);
  localparam logic [7:0] PAD = 8'hF7;

  logic ts1, ts2, lnk_en, num_en, lane_en;

  assign ts1     = (ls_i == 4'd2) || (ls_i >= 4'd4 && ls_i <= 4'd7);
  assign ts2     = (ls_i == 4'd3) || (ls_i == 4'd8);
  assign lnk_en  = (DEVICETYPE == 0) ? (ls_i >= 4'd4 && ls_i <= 4'd9)
                                     : (ls_i >= 4'd5 && ls_i <= 4'd9);
  assign num_en  = (ls_i >= 4'd6 && ls_i <= 4'd9);
  // counts above 16 enable every lane, since LANE never exceeds 15
  assign lane_en = 5'(LANE) < nlanes_i;

  always_comb begin
    os_o = '0;
    if (lane_en && (ts1 || ts2)) begin
      os_o[7:0]   = 8'hBC;
      os_o[15:8]  = lnk_en ? link_i : PAD;
      os_o[23:16] = num_en ? 8'(LANE) : PAD;
      os_o[31:24] = NFTS;
      os_o[39:32] = {upcfg_i, rate_i};
      os_o[47:40] = 8'h00;
      for (int k = 6; k < 16; k++) os_o[8*k +: 8] = ts1 ? 8'h4A : 8'h45;
    end
  end
endmodule

module tx_ltssm #(
  parameter int         DEVICETYPE = 0,
  parameter logic [7:0] NFTS       = 8'd255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [3:0]    substate,
  input  logic [7:0]    linkNumber,
  input  logic [7:0]    rateId,
  input  logic          upConfigureCapability,
  input  logic [4:0]    numberOfDetectedLanes,
  input  logic          rxDone,
  input  logic          osReady,
  output logic [2047:0] orderedSets,
  output logic          osValid,
  output logic          finish,
  output logic          busy,
  output logic          txElectricalIdle,
  output logic          disableScrambler
);
`ifdef TX_LTSSM_FAST_SIM_EN
  localparam logic [11:0] PA_MIN = 12'd16;
`else
  localparam logic [11:0] PA_MIN = 12'd1024;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      ls_q, ls_d;
  logic [10:0]     sent_q, sent_d;
  logic [4:0]      post_q, post_d;
  logic            rxseen_q, rxseen_d;
  logic [2047:0]   os_q, os_d;
  logic            osvalid_q, osvalid_d;
  logic            finish_q, finish_d;
  logic            busy_q, busy_d;
  logic            txei_q, txei_d;
  logic            dscr_q, dscr_d;

  logic [15:0][127:0] lane_os;
  logic [11:0]     min_q;
  logic [4:0]      postmin_q;
  logic [10:0]     sent_inc;
  logic [4:0]      post_inc;
  logic            xfer;
  logic            unused_rate7;

  assign unused_rate7 = rateId[7];

  for (genvar g = 0; g < 16; g++) begin : g_lane
    tx_ltssm_lane #(.LANE(g), .DEVICETYPE(DEVICETYPE), .NFTS(NFTS)) u_lane (
      .ls_i     (substate),
      .link_i   (linkNumber),
      .rate_i   (rateId[6:0]),
      .upcfg_i  (upConfigureCapability),
      .nlanes_i (numberOfDetectedLanes),
      .os_o     (lane_os[g])
    );
  end

  always_comb begin
    min_q     = 12'd0;
    postmin_q = 5'd0;
    case (ls_q)
      4'd2:                min_q     = PA_MIN;
      4'd3, 4'd8, 4'd9:    postmin_q = 5'd16;
      default: ;
    endcase
  end

  assign xfer     = (state_q == S_SEND) && osReady;
  assign sent_inc = (sent_q == 11'h7FF) ? sent_q : sent_q + 11'd1;
  // post only advances on transfers that follow an already-recorded rxDone
  assign post_inc = (!rxseen_q || post_q == 5'd31) ? post_q : post_q + 5'd1;

  always_comb begin
    state_d  = state_q;
    ls_d     = ls_q;
    sent_d   = sent_q;
    post_d   = post_q;
    rxseen_d = rxseen_q;
    os_d     = os_q;
    txei_d   = txei_q;
    case (state_q)
      S_IDLE: if (start) begin
        ls_d     = substate;
        sent_d   = '0;
        post_d   = '0;
        rxseen_d = 1'b0;
        os_d     = lane_os;
        if (substate >= 4'd2 && substate <= 4'd9) begin
          state_d = S_SEND;
          txei_d  = 1'b0;
        end else begin
          state_d = S_DONE;
          if (substate <= 4'd1) txei_d = 1'b1;
        end
      end
      S_SEND: begin
        if (rxDone) rxseen_d = 1'b1;
        if (xfer) begin
          sent_d = sent_inc;
          post_d = post_inc;
          if (({1'b0, sent_q} + 12'd1 >= min_q) && (post_inc >= postmin_q) &&
              (rxseen_q || rxDone))
            state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    osvalid_d = (state_d == S_SEND);
    finish_d  = (state_d == S_DONE);
    busy_d    = (state_d != S_IDLE);
    dscr_d    = !(ls_d == 4'd9 || ls_d == 4'd10);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ls_q      <= '0;
      sent_q    <= '0;
      post_q    <= '0;
      rxseen_q  <= 1'b0;
      os_q      <= '0;
      osvalid_q <= 1'b0;
      finish_q  <= 1'b0;
      busy_q    <= 1'b0;
      txei_q    <= 1'b1;
      dscr_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      ls_q      <= ls_d;
      sent_q    <= sent_d;
      post_q    <= post_d;
      rxseen_q  <= rxseen_d;
      os_q      <= os_d;
      osvalid_q <= osvalid_d;
      finish_q  <= finish_d;
      busy_q    <= busy_d;
      txei_q    <= txei_d;
      dscr_q    <= dscr_d;
    end
  end

  assign orderedSets      = os_q;
  assign osValid          = osvalid_q;
  assign finish           = finish_q;
  assign busy             = busy_q;
  assign txElectricalIdle = txei_q;
  assign disableScrambler = dscr_q;
endmodule

// File: tb/tb_tx_ltssm.sv
// Scoreboard bench for tx_ltssm: the driver pushes one expected record per training run,
// the monitor counts transfers and checks data/status when finish appears.
module tb_tx_ltssm;
`ifdef TX_LTSSM_FAST_SIM_EN
  localparam int PA_N = 16, PA_RX = 10;
`else
  localparam int PA_N = 1024, PA_RX = 100;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start = 1'b0;
  logic [3:0]    substate = '0;
  logic [7:0]    linkNumber = '0;
  logic [7:0]    rateId = '0;
  logic          upConfigureCapability = 1'b0;
  logic [4:0]    numberOfDetectedLanes = '0;
  logic          rxDone = 1'b0;
  logic          osReady = 1'b0;
  logic [2047:0] orderedSets;
  logic          osValid, finish, busy, txElectricalIdle, disableScrambler;

  tx_ltssm #(.DEVICETYPE(0), .NFTS(8'hFF)) dut (
    .clk(clk), .reset(reset), .start(start), .substate(substate),
    .linkNumber(linkNumber), .rateId(rateId),
    .upConfigureCapability(upConfigureCapability),
    .numberOfDetectedLanes(numberOfDetectedLanes), .rxDone(rxDone),
    .osReady(osReady), .orderedSets(orderedSets), .osValid(osValid),
    .finish(finish), .busy(busy), .txElectricalIdle(txElectricalIdle),
    .disableScrambler(disableScrambler)
  );

  always #5 clk = ~clk;

  typedef struct {
    string         name;
    int            xfers;
    logic [2047:0] os;
    logic          dscr;
    logic          txei;
    bit            sent;
    int            start_cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0, pops = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // Lane image from hand-picked byte values; sym==0 gives an Idle (all-zero) set.
  function automatic logic [2047:0] mk_os(input logic [7:0] sym, input logic [7:0] b1,
                                          input logic [7:0] b4, input bit idx, input int nl);
    logic [2047:0] v;
    logic [7:0]    b2;
    v = '0;
    for (int l = 0; l < 16; l++) begin
      b2 = idx ? 8'(l) : 8'hF7;
      if (l < nl && sym != 8'h00)
        v[l*128 +: 128] = {{10{sym}}, 8'h00, b4, 8'hFF, b2, b1, 8'hBC};
    end
    return v;
  endfunction

  // ---------------- monitor ----------------
  int            mx = 0, lastx = 0, bad_lane = 0;
  bit            dok = 1, stall_p = 0, fin_p = 0;
  logic [127:0]  bad_got, bad_want;
  logic [2047:0] prev_os, want_os;
  exp_t          e;

  always @(negedge clk) begin
    if (reset) begin
      mx = 0; dok = 1; stall_p = 0; fin_p = 0;
    end else begin
      if (fin_p) chk("finish_pulse_width", finish, 0);
      want_os = (sb.size() > 0) ? sb[0].os : '0;
      if (stall_p) want_os = prev_os;
      if ((osValid && osReady) || stall_p) begin
        for (int l = 0; l < 16; l++)
          if (dok && orderedSets[l*128 +: 128] !== want_os[l*128 +: 128]) begin
            dok = 0; bad_lane = l;
            bad_got = orderedSets[l*128 +: 128]; bad_want = want_os[l*128 +: 128];
          end
      end
      if (osValid && osReady) begin mx++; lastx = cyc; end
      stall_p = osValid && !osReady;
      prev_os = orderedSets;
      if (finish) begin
        if (sb.size() == 0) chk("unexpected_finish", 1, 0);
        else begin
          e = sb.pop_front();
          chk({e.name, " xfers"}, mx, e.xfers);
          checks++;
          if (!dok) begin
            errors++;
            $display("FAIL %s data lane %0d: got %h want %h", e.name, bad_lane, bad_got, bad_want);
          end
          chk({e.name, " finish_cycle"}, cyc, e.sent ? lastx + 1 : e.start_cyc + 1);
          chk({e.name, " osValid_at_finish"}, osValid, 0);
          chk({e.name, " busy_at_finish"}, busy, 1);
          chk({e.name, " disableScrambler"}, disableScrambler, e.dscr);
          chk({e.name, " txElectricalIdle"}, txElectricalIdle, e.txei);
          pops++;
        end
        mx = 0; dok = 1;
      end
      fin_p = finish;
    end
  end

  // ---------------- driver ----------------
  task automatic run(input string nm, input logic [3:0] sub, input logic [7:0] lnk,
                     input logic [7:0] rate, input logic up, input logic [4:0] nl,
                     input logic [2047:0] eos, input int exp_x, input logic e_dscr,
                     input logic e_txei, input int rx_at, input bit tog,
                     input int busy_at, input int abort_at);
    exp_t r;
    int   dn, pops0;
    bit   done;
    @(posedge clk); #1;
    substate = sub; linkNumber = lnk; rateId = rate;
    upConfigureCapability = up; numberOfDetectedLanes = nl;
    if (abort_at == 0) begin
      r.name = nm; r.xfers = exp_x; r.os = eos; r.dscr = e_dscr; r.txei = e_txei;
      r.sent = (sub >= 4'd2 && sub <= 4'd9); r.start_cyc = cyc;
      sb.push_back(r);
    end
    pops0 = pops; start = 1'b1; dn = 0; osReady = 1'b0; done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(posedge clk); #1;
      start = 1'b0; rxDone = 1'b0;
      if (pops != pops0) done = 1;
      else begin
        osReady = tog ? ~osReady : 1'b1;
        if (osValid && osReady) begin
          dn++;
          if (dn == rx_at) rxDone = 1'b1;
          if (dn == busy_at) begin
            start = 1'b1; substate = 4'd4; rateId = 8'h7F; linkNumber = 8'hAA;
          end
          if (abort_at != 0 && dn == abort_at) begin
            #2 reset = 1'b1;
            #1;
            chk({nm, " osValid_after_reset"}, osValid, 0);
            chk({nm, " finish_after_reset"}, finish, 0);
            chk({nm, " busy_after_reset"}, busy, 0);
            repeat (2) @(posedge clk);
            #1 reset = 1'b0;
            done = 1;
          end
        end
      end
    end
    if (!done) begin
      chk({nm, " timeout"}, 1, 0);
      reset = 1'b1; #1; sb.delete(); @(posedge clk); #1 reset = 1'b0;
    end
    osReady = 1'b0; rxDone = 1'b0; start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    #1;
    chk("reset osValid", osValid, 0);
    chk("reset finish", finish, 0);
    chk("reset busy", busy, 0);
    chk("reset txElectricalIdle", txElectricalIdle, 1);
    chk("reset disableScrambler", disableScrambler, 1);
    chk("reset orderedSets_zero", orderedSets == '0, 1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Polling.Active: PAD link/lane, byte4 = {1,7'h02} = 8'h82, 4 lanes of TS1
    run("polling_active", 4'd2, 8'h05, 8'h02, 1'b1, 5'd4,
        mk_os(8'h4A, 8'hF7, 8'h82, 0, 4), PA_N, 1'b1, 1'b0, PA_RX, 0, 0, 0);
    // substate 0: straight to DONE, idle request re-asserted
    run("substate0", 4'd0, 8'h00, 8'h00, 1'b0, 5'd4,
        '0, 0, 1'b1, 1'b1, 0, 0, 0, 0);
    // Config.Complete: rxDone on transfer 5, then 16 more -> 21
    run("config_complete", 4'd8, 8'h03, 8'h81, 1'b0, 5'd2,
        mk_os(8'h45, 8'h03, 8'h01, 1, 2), 21, 1'b1, 1'b0, 5, 0, 0, 0);
    // Config.Idle with osReady toggling: rxDone on transfer 3 -> 19
    run("config_idle", 4'd9, 8'h03, 8'h01, 1'b0, 5'd8,
        '0, 19, 1'b0, 1'b0, 3, 1, 0, 0);
    // Linkwidth.Start: downstream advertises link; finishes on the rxDone transfer
    run("linkwidth_start", 4'd4, 8'h11, 8'h03, 1'b0, 5'd16,
        mk_os(8'h4A, 8'h11, 8'h03, 0, 16), 1, 1'b1, 1'b0, 1, 0, 0, 0);
    // Lanenum.Wait with lane count 20 -> all 16 lanes numbered
    run("lanenum_wait_20", 4'd6, 8'h22, 8'hFF, 1'b1, 5'd20,
        mk_os(8'h4A, 8'h22, 8'hFF, 1, 16), 2, 1'b1, 1'b0, 2, 0, 0, 0);
    // Polling.Configuration with start/substate/rate/link changes mid-run
    run("busy_restart_ignored", 4'd3, 8'h09, 8'h01, 1'b0, 5'd1,
        mk_os(8'h45, 8'hF7, 8'h01, 0, 1), 18, 1'b1, 1'b0, 2, 0, 6, 0);
    // Reset mid Polling.Configuration, then a clean rerun from zero counts
    run("abort", 4'd3, 8'h00, 8'h01, 1'b0, 5'd4,
        '0, 0, 1'b1, 1'b0, 0, 0, 0, 5);
    chk("abort txElectricalIdle", txElectricalIdle, 1);
    run("after_abort", 4'd3, 8'h00, 8'h01, 1'b0, 5'd4,
        mk_os(8'h45, 8'hF7, 8'h01, 0, 4), 17, 1'b1, 1'b0, 1, 0, 0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
